// File: rtl/cic_pkg.sv
// Shared CIC definitions used by the interpolator and decimator.
//   cic_state_e    : handshake state (IDLE / EMIT)
//   cic_clog2      : ceil(log2(v)), usable in constant expressions
//   cic_out_w      : output width from structural parameters
//   cic_params_ok  : legality of N / R / M
package cic_pkg;

  typedef enum logic {IDLE, EMIT} cic_state_e;

  function automatic int cic_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bit growth: IN_W + N*clog2(R*M) - clog2(R).
  function automatic int cic_out_w(input int in_w, input int n, input int r, input int m);
    return in_w + n * cic_clog2(r * m) - cic_clog2(r);
  endfunction

  function automatic bit cic_params_ok(input int n, input int r, input int m);
    return (n >= 1) && (n <= 6) && (r >= 2) && ((r & (r - 1)) == 0) &&
           ((m == 1) || (m == 2));
  endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// Cascade of N OUT_W-bit integrators running at the output rate.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_u          : zero-stuffed input sample (already sign-extended)
//   i_advance    : commit the next values (output handshake)
//   o_next       : combinational next value of the last integrator (IN')
// Each stage adds the *next* value of the previous stage, so the final
// output appears in the same cycle its input sample is presented.
module cic_integrator_chain #(
  parameter int N     = 3,
  parameter int OUT_W = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OUT_W-1:0] i_u,
  input  logic             i_advance,
  output logic [OUT_W-1:0] o_next
);

  // Two's-complement wrap is intentional; unsigned add is bit-identical.
  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_sum;

    if (k == 0) begin : g_first
      assign w_sum = r_acc + i_u;
    end else begin : g_rest
      assign w_sum = r_acc + g_stage[k-1].w_sum;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst)          r_acc <= '0;
      else if (i_advance) r_acc <= w_sum;
    end
  end

  assign o_next = g_stage[N-1].w_sum;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator, ratio R, differential delay M.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_data, i_valid    : low-rate signed input sample and its valid
//   o_ready            : input accepted this cycle when i_valid is high
//   o_data, o_valid    : high-rate signed output sample and its valid
//   i_ready            : downstream accepts o_data
// Every accepted input yields exactly R outputs; a new input can be taken
// on the last output handshake of a burst so bursts run without bubbles.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter  int IN_W  = 16,
  parameter  int N     = 3,
  parameter  int R     = 4,
  parameter  int M     = 1,
  localparam int OUT_W = cic_out_w(IN_W, N, R, M)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  if (!cic_params_ok(N, R, M)) begin : g_bad_params
    $error("cic_interpolator: illegal N/R/M combination");
  end

  localparam int CW = IN_W + N;                     // final comb stage width
  localparam int XW = (OUT_W > CW) ? OUT_W : CW;    // common extension width
  localparam int PW = cic_clog2(R);
  localparam logic [PW-1:0] P_LAST = PW'(R - 1);

  cic_state_e             r_state;
  logic [PW-1:0]          r_p;
  logic signed [CW-1:0]   r_c;
  logic signed [CW-1:0]   r_dly [N][M];

  logic signed [CW-1:0]   w_c [N+1];
  logic signed [XW-1:0]   w_cx;
  logic [OUT_W-1:0]       w_u;
  logic                   w_accept;
  logic                   w_advance;
  logic                   w_last;

  assign w_last    = (r_p == P_LAST);
  assign o_ready   = (r_state == IDLE) || (w_last && i_ready);
  assign w_accept  = i_valid && o_ready;
  assign w_advance = (r_state == EMIT) && i_ready;
  assign o_valid   = (r_state == EMIT);

  // Comb stages are computed at the final width; stage k's value fits in
  // IN_W+k bits, so the wider arithmetic is exact.
  always_comb begin
    w_c[0] = {{N{i_data[IN_W-1]}}, i_data};
    for (int unsigned k = 0; k < N; k++) begin
      w_c[k+1] = w_c[k] - r_dly[k][M-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        for (int unsigned m = 0; m < M; m++) r_dly[k][m] <= '0;
      end
      r_c <= '0;
    end else if (w_accept) begin
      for (int unsigned k = 0; k < N; k++) begin
        r_dly[k][0] <= w_c[k];
        for (int unsigned m = 1; m < M; m++) r_dly[k][m] <= r_dly[k][m-1];
      end
      r_c <= w_c[N];
    end
  end

  // Zero stuffer: comb result on phase 0, zeros on the remaining phases.
  // Truncation when OUT_W < CW is harmless because integrators wrap.
  assign w_cx = XW'(r_c);
  assign w_u  = ((r_state == EMIT) && (r_p == '0)) ? w_cx[OUT_W-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_p     <= '0;
    end else if (w_accept) begin
      r_state <= EMIT;
      r_p     <= '0;
    end else if (w_advance) begin
      if (w_last) begin
        r_state <= IDLE;
        r_p     <= '0;
      end else begin
        r_p <= r_p + PW'(1);
      end
    end
  end

  cic_integrator_chain #(
    .N     (N),
    .OUT_W (OUT_W)
  ) u_integ (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_u       (w_u),
    .i_advance (w_advance),
    .o_next    (o_data)
  );

endmodule
